// File: rtl/bt_msg_pkg.sv
// ----------------------------------------------------------------------------
// bt_msg_pkg
// Shared definitions for the Bluetooth message arbiter:
//   - baud_div()   : clock cycles per UART bit (integer-truncated)
//   - TERM_BYTE    : '#' message terminator
//   - arb_state_t  : arbiter FSM state encoding
//   - MSG_TABLE    : fixed ASCII message per requester, 16 characters each
//   - msg_byte()   : byte lookup used to build the message ROM
// ----------------------------------------------------------------------------
package bt_msg_pkg;

    localparam logic [7:0] TERM_BYTE = 8'h23;   // '#'
    localparam int         MSG_CHARS = 16;      // characters stored per table row
    localparam int         MAX_REQ   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } arb_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // First character sits in the most significant byte of each row.
    // Rows are padded with spaces after the terminator. Row 3 deliberately
    // carries no terminator so the MSG_LEN byte limit is what ends it.
    localparam logic [8*MSG_CHARS-1:0] MSG_TABLE [MAX_REQ] = '{
        "FIM-CSU1-#      ",
        "LINE-OK-#       ",
        "PICKUP-#        ",
        "NO-TERMINATOR-AB",
        "REQ4-#          ",
        "REQ5-#          ",
        "REQ6-#          ",
        "REQ7-#          "
    };

    // Anything outside the table reads as a terminator, so a ROM deeper
    // than the table still ends every message cleanly.
    function automatic logic [7:0] msg_byte(input int msg, input int idx);
        logic [8*MSG_CHARS-1:0] row;
        if (msg < 0 || msg >= MAX_REQ || idx < 0 || idx >= MSG_CHARS) begin
            return TERM_BYTE;
        end
        row = MSG_TABLE[msg];
        return row[8*(MSG_CHARS-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// ----------------------------------------------------------------------------
// uart_tx_8n1
// 8N1 UART transmitter: start bit (0), 8 data bits LSB first, stop bit (1),
// each bit BAUD_DIV clock cycles long.
// Ports:
//   clk_50M  in   system clock
//   rst      in   synchronous active-high reset (line returns high next edge)
//   start    in   one-cycle request to send data; ignored while busy
//   data     in   byte to send, sampled with start
//   tx       out  serial line, idle high
//   busy     out  high while a frame is on the line
//   done     out  one-cycle pulse in the last cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_8n1 #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;   // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]       shift_q,    shift_d;     // remaining data bits plus stop bit
    logic             tx_q,       tx_d;
    logic             active_q,   active_d;
    logic             bit_end;

    assign bit_end = active_q && (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        active_d   = active_q;
        if (!active_q) begin
            if (start) begin
                active_d   = 1'b1;
                tx_d       = 1'b0;
                shift_d    = {1'b1, data};
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        end else if (bit_end) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                tx_d      = shift_q[0];
                shift_d   = {1'b1, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
        end
    end

    assign tx   = tx_q;
    assign busy = active_q;
    assign done = bit_end && (bit_cnt_q == 4'd9);

endmodule

// File: rtl/bt_msg_arbiter.sv
// ----------------------------------------------------------------------------
// bt_msg_arbiter
// Round-robin scheduler sharing one UART transmit line between N_REQ
// requesters. Each request pulse latches a pending bit; one requester at a
// time is granted and its fixed ASCII message is streamed from a ROM through
// an 8N1 serializer until '#' or MSG_LEN bytes.
// Ports:
//   clk_50M   in   system clock
//   rst       in   synchronous active-high reset
//   req       in   per-requester one-cycle request pulses
//   tx        out  UART line to the Bluetooth module, idle high
//   busy      out  high from grant until the DONE state completes
//   grant_id  out  requester being served; holds last value when idle
//   done      out  one-cycle pulse on bit i when message i has left the line
//   dropped   out  one-cycle pulse on bit i when req[i] hits a pending i
// ----------------------------------------------------------------------------
module bt_msg_arbiter
    import bt_msg_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int N_REQ   = 4,
    parameter int MSG_LEN = 16
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         dropped
);

    localparam int BAUD_DIV  = baud_div(CLK_HZ, BAUD);
    localparam int GID_W     = $clog2(N_REQ);
    localparam int IDX_W     = $clog2(MSG_LEN);
    localparam int ROM_DEPTH = N_REQ * MSG_LEN;
    localparam int ADDR_W    = $clog2(ROM_DEPTH);

    arb_state_t        state_q,      state_d;
    logic [N_REQ-1:0]  pending_q,    pending_d;
    logic [GID_W-1:0]  grant_id_q,   grant_id_d;
    logic [GID_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic              busy_q,       busy_d;
    logic [N_REQ-1:0]  done_q,       done_d;
    logic [N_REQ-1:0]  dropped_q,    dropped_d;
    logic [N_REQ-1:0]  grant_clr;

    logic [GID_W-1:0]  pick_id;
    logic              pick_found;
    int                cand;

    logic [7:0]        rom [ROM_DEPTH];
    logic [7:0]        rom_data_q;
    logic [ADDR_W-1:0] rom_addr;

    logic              ser_start;
    logic              ser_busy;
    logic              ser_done;
    logic              ser_tx;

    // ------------------------------------------------------------------
    // Message ROM: row-major, one MSG_LEN slot per requester.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            assign rom[gi] = msg_byte(gi / MSG_LEN, gi % MSG_LEN);
        end
    endgenerate

    assign rom_addr = ADDR_W'(grant_id_q) * ADDR_W'(MSG_LEN) + ADDR_W'(idx_q);

    // Read every cycle; the address only moves on grant or on WAIT->LOAD, so
    // the byte seen in SEND and WAIT is the one fetched during LOAD.
    always_ff @(posedge clk_50M) begin
        rom_data_q <= rom[rom_addr];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first pending bit after last_grant, with wrap.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(last_grant_q) + 1 + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_found && pending_q[cand]) begin
                pick_found = 1'b1;
                pick_id    = GID_W'(cand);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = '0;
        grant_clr    = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d         = pick_id;
                    grant_clr[pick_id] = 1'b1;
                    idx_d              = '0;
                    busy_d             = 1'b1;
                    state_d            = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // The serializer is always free here; the guard only keeps a
                // start from being lost if that ever stops being true.
                if (!ser_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ser_done) begin
                    if (rom_data_q == TERM_BYTE || idx_q == IDX_W'(MSG_LEN - 1)) begin
                        done_d[grant_id_q] = 1'b1;
                        state_d            = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                last_grant_d = grant_id_q;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A request landing on the grant cycle re-queues (set beats clear)
        // and is not a drop, since the granted copy is already consumed.
        pending_d = (pending_q & ~grant_clr) | req;
        dropped_d = req & pending_q & ~grant_clr;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= GID_W'(N_REQ - 1);
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= '0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dropped_q    <= dropped_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    assign ser_start = (state_q == ST_SEND) && !ser_busy;

    uart_tx_8n1 #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk_50M (clk_50M),
        .rst     (rst),
        .start   (ser_start),
        .data    (rom_data_q),
        .tx      (ser_tx),
        .busy    (ser_busy),
        .done    (ser_done)
    );

    assign tx       = ser_tx;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign done     = done_q;
    assign dropped  = dropped_q;

endmodule
